// File: rtl/shifter_pkg.sv
// ----------------------------------------------------------------------------
// shifter_pkg
// Shared types for the parameterised shift-register block.
//   mode_t  : shift operation selected at load time (SLL, SRL, SRA, ROL)
//   state_t : control FSM states (IDLE, SHIFT, DONE)
//   shifts_right() : true for the modes whose shifted-out bit feeds sticky
// ----------------------------------------------------------------------------
package shifter_pkg;

   typedef enum logic [1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SRA = 2'b10,
      ROL = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // Only right shifts discard bits off the LSB end that matter for sticky.
   function automatic logic shifts_right(mode_t m);
      return (m == SRL) || (m == SRA);
   endfunction

endpackage

// File: rtl/shifter_step.sv
// ----------------------------------------------------------------------------
// shifter_step
// Purely combinational single-bit shift step.
// Ports:
//   mode        : operation to apply (SLL, SRL, SRA, ROL)
//   din         : current register value
//   dout        : register value after one step
//   shifted_out : the bit leaving the register on this step (for ROL it is
//                 the bit wrapped around from MSB to LSB)
// ----------------------------------------------------------------------------
module shifter_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  mode_t             mode,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic              shifted_out
);

   // One step of the selected operation; SRA keeps the sign bit in place
   // and copies it downward, ROL recirculates the MSB into the LSB.
   always_comb begin
      dout        = din;
      shifted_out = 1'b0;
      case (mode)
         SLL: begin
            dout        = {din[WIDTH-2:0], 1'b0};
            shifted_out = din[WIDTH-1];
         end
         SRL: begin
            dout        = {1'b0, din[WIDTH-1:1]};
            shifted_out = din[0];
         end
         SRA: begin
            dout        = {din[WIDTH-1], din[WIDTH-1:1]};
            shifted_out = din[0];
         end
         ROL: begin
            dout        = {din[WIDTH-2:0], din[WIDTH-1]};
            shifted_out = din[WIDTH-1];
         end
         default: begin
            dout        = din;
            shifted_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shifter_param.sv
// ----------------------------------------------------------------------------
// shifter_param
// Multi-cycle shift register: loads SI on start, then applies `amt`
// single-bit steps of the latched mode, one per clock with shn high, and
// pulses done for one cycle at the end.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   SI     : parallel load data
//   start  : load SI and begin an operation (honoured in IDLE only)
//   mode   : 00 SLL, 01 SRL, 10 SRA, 11 ROL (latched at load)
//   amt    : number of single-bit steps (latched at load)
//   shn    : shift enable; low pauses the operation in SHIFT
//   SO     : shift register contents (direct register output)
//   busy   : high while in SHIFT
//   done   : one-cycle completion pulse
//   sticky : OR of all bits shifted out by SRL/SRA steps
//            (present only when SHIFTER_STICKY_EN is defined)
// Configuration macro: SHIFTER_STICKY_EN
// ----------------------------------------------------------------------------
module shifter_param
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  SI,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [AW-1:0]     amt,
   input  logic              shn,
   output logic [WIDTH-1:0]  SO,
   output logic              busy,
   output logic              done
`ifdef SHIFTER_STICKY_EN
   ,
   output logic              sticky
`endif
);

   state_t            state;
   mode_t             mode_q;
   logic [AW-1:0]     cnt;
   logic [WIDTH-1:0]  step_out;
   logic              step_bit;

   shifter_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .mode        (mode_q),
      .din         (SO),
      .dout        (step_out),
      .shifted_out (step_bit)
   );

   // Control FSM, step counter and data register. mode and amt are captured
   // on the load edge so later changes on the inputs cannot disturb an
   // operation in progress. A zero amount skips SHIFT entirely.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         mode_q <= SLL;
         cnt    <= '0;
         SO     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  SO     <= SI;
                  mode_q <= mode_t'(mode);
                  cnt    <= amt;
                  state  <= (amt != '0) ? SHIFT : DONE;
               end
            end
            SHIFT: begin
               if (shn) begin
                  SO  <= step_out;
                  cnt <= cnt - AW'(1);
                  if (cnt == AW'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

`ifdef SHIFTER_STICKY_EN
   // Sticky accumulates bits falling off the LSB during right shifts. It is
   // cleared on the load edge and otherwise held, so it stays valid through
   // done and until the next load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sticky <= 1'b0;
      end else if ((state == IDLE) && start) begin
         sticky <= 1'b0;
      end else if ((state == SHIFT) && shn && shifts_right(mode_q)) begin
         sticky <= sticky | step_bit;
      end
   end
`else
   logic unused_step_bit;
   assign unused_step_bit = step_bit;
`endif

endmodule

// File: tb/tb_shifter_param.sv
// ----------------------------------------------------------------------------
// tb_shifter_param
// Scoreboard bench for shifter_param (WIDTH=8). Each issued operation pushes
// its expected result onto a queue; an independent monitor pops and compares
// whenever the DUT raises done. Expected values come from an arithmetic
// reference model (whole-word shifts/rotates, not step-by-step).
// Optional feature macro checked when defined: SHIFTER_STICKY_EN
// ----------------------------------------------------------------------------
module tb_shifter_param;

   localparam int WIDTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b1;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] si = '0;
   logic             start = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [AW-1:0]    amt = '0;
   logic             shn = 1'b1;
   logic [WIDTH-1:0] so;
   logic             busy;
   logic             done;
`ifdef SHIFTER_STICKY_EN
   logic             sticky;
`endif

   typedef struct {
      logic [7:0] so;
      logic       stk;
      int         amt;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks    = 0;
   int         passed    = 0;
   int         cyc       = 0;
   int         load_cyc  = 0;
   int         pause_cnt = 0;
   int         done_cnt  = 0;
   logic       done_prev = 1'b0;
   logic [7:0] last_so   = '0;

   shifter_param #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .SI    (si),
      .start (start),
      .mode  (mode),
      .amt   (amt),
      .shn   (shn),
      .SO    (so),
      .busy  (busy),
      .done  (done)
`ifdef SHIFTER_STICKY_EN
      ,
      .sticky (sticky)
`endif
   );

   // Clock starts high so the first edge after time 0 is a falling edge;
   // the first rising edge is at 10ns.
   always #5 clk = ~clk;

   // Rising-edge counter used to measure latency from the load edge.
   always @(posedge clk) cyc++;

   // Single comparison point: every check steps checks/passed.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   // Reference result of n whole-word steps, computed arithmetically.
   function automatic logic [7:0] refSo(input logic [7:0] x, input logic [1:0] m, input int n);
      logic signed [7:0] s;
      logic [7:0]        r;
      case (m)
         2'b00: r = x << n;
         2'b01: r = x >> n;
         2'b10: begin s = x; s = s >>> n; r = s; end
         default: r = (x << n) | (x >> (8 - n));
      endcase
      return r;
   endfunction

   // Sticky = OR of the n low bits that right shifts discard.
   function automatic logic refSticky(input logic [7:0] x, input logic [1:0] m, input int n);
      logic [7:0] msk;
      msk = 8'((9'd1 << n) - 9'd1);
      if (m == 2'b01 || m == 2'b10) return |(x & msk);
      return 1'b0;
   endfunction

   // Monitor: on every done, pop the oldest expectation and compare result,
   // latency (amt+1 plus paused cycles), busy, pulse width and sticky.
   always @(negedge clk) begin
      if (rst && done) begin
         done_cnt++;
         checkOutput("done_expected", 32'(exp_q.size() != 0), 32'd1);
         checkOutput("done_pulse_width", 32'(done_prev), 32'd0);
         checkOutput("busy_during_done", 32'(busy), 32'd0);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("so_at_done", 32'(so), 32'(mon_e.so));
            checkOutput("latency", 32'(cyc - load_cyc), 32'(mon_e.amt + 1 + pause_cnt));
`ifdef SHIFTER_STICKY_EN
            checkOutput("sticky_at_done", 32'(sticky), 32'(mon_e.stk));
`endif
         end
      end
      done_prev = rst && done;
   end

   // Issue one operation and steer shn/noise until the block leaves SHIFT.
   // pause_at/pause_len force shn low on chosen busy cycles; noisy toggles
   // shn randomly and hammers start/SI/mode/amt while busy.
   task automatic applyStimulus(input logic [7:0] s, input logic [1:0] m, input int n,
                                input int pause_at, input int pause_len, input bit noisy);
      exp_t e;
      bit   finished;
      finished = 1'b0;
      @(negedge clk);
      si        = s;
      mode      = m;
      amt       = AW'(n);
      start     = 1'b1;
      shn       = 1'b1;
      load_cyc  = cyc;
      pause_cnt = 0;
      e.so  = refSo(s, m, n);
      e.stk = refSticky(s, m, n);
      e.amt = n;
      exp_q.push_back(e);
      last_so = e.so;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         start = 1'b0;
         shn   = 1'b1;
         if (k == 0 && n == 0) checkOutput("zero_amt_busy", 32'(busy), 32'd0);
         if (k > pause_at && k <= pause_at + pause_len)
            checkOutput("pause_hold", 32'(so), 32'(refSo(s, m, pause_at)));
         if (busy) begin
            if (k >= pause_at && k < pause_at + pause_len) shn = 1'b0;
            else if (noisy) shn = ($urandom_range(0, 3) != 0);
            if (!shn) pause_cnt++;
            if (noisy) begin
               start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
               si    = 8'hFF;
               mode  = 2'($urandom_range(0, 3));
               amt   = AW'($urandom_range(0, 7));
            end
         end else begin
            finished = 1'b1;
            break;
         end
      end
      start = 1'b0;
      shn   = 1'b1;
      if (!finished) checkOutput("op_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int saved;
      // Reset state before any rising edge.
      rst = 1'b0;
      #1;
      checkOutput("reset_so", 32'(so), 32'h00);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      #2 rst = 1'b1;

      // Directed operations; the first load lands on the first rising edge.
      applyStimulus(8'h90, 2'b01, 2, -1, 0, 1'b0);   // SRL -> 24
      applyStimulus(8'h90, 2'b10, 2, -1, 0, 1'b0);   // SRA -> E4
      applyStimulus(8'h81, 2'b11, 1, -1, 0, 1'b0);   // ROL -> 03
      applyStimulus(8'h81, 2'b00, 0, -1, 0, 1'b0);   // zero amount -> 81
      applyStimulus(8'h81, 2'b00, 3, 1, 2, 1'b0);    // pause: hold 02, final 08
      applyStimulus(8'h90, 2'b10, 2, -1, 0, 1'b1);   // start with FF while busy ignored
      applyStimulus(8'h91, 2'b01, 2, -1, 0, 1'b0);   // sticky=1
      applyStimulus(8'h90, 2'b01, 2, -1, 0, 1'b0);   // sticky=0

      // IDLE holds SO while SI wanders and start stays low.
      repeat (3) begin
         @(negedge clk);
         si = 8'($urandom);
      end
      checkOutput("idle_hold", 32'(so), 32'(last_so));

      // Abort: reset mid-SHIFT clears SO at once and yields no done.
      @(negedge clk);
      si = 8'h81; mode = 2'b00; amt = 3'd5; start = 1'b1; shn = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      saved = done_cnt;
      rst = 1'b0;
      #1;
      checkOutput("abort_so", 32'(so), 32'h00);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("abort_no_done", 32'(done_cnt), 32'(saved));

      // Randomised operations with random pauses and start/mode/amt noise.
      for (int i = 0; i < 25; i++) begin
         applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                       -1, 0, 1'b1);
      end

      repeat (3) @(negedge clk);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global bound so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
